// File: rtl/qmeas_pkg.sv
// Shared types and helpers for qubit_measure_sampler: FSM state encoding,
// default probability width and the single-shot outcome rule.
package qmeas_pkg;

    localparam int PROB_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Outcome |1> when the random byte does not exceed the scaled probability,
    // so a zero byte always reads as |1>.
    function automatic logic outcome_one(input logic [PROB_W_DEF-1:0] rnd,
                                         input logic [PROB_W_DEF-1:0] prob1);
        return rnd <= prob1;
    endfunction

endpackage

// File: rtl/qubit_measure_sampler.sv
// Projective-measurement sampler: one LFSR byte per shot, |0>/|1> counts out via valid/ready.
// Optional QMEAS_STREAM_EN adds a registered per-shot stream (shot_valid_o, shot_bit_o).
module qubit_measure_sampler
    import qmeas_pkg::*;
#(
    parameter int SHOTS_W = 16,
    parameter int PROB_W  = PROB_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PROB_W-1:0]  rnd_i,
    input  logic               rnd_valid_i,
    input  logic               start_i,
    input  logic [PROB_W-1:0]  prob1_i,
    input  logic [SHOTS_W-1:0] shots_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic [SHOTS_W-1:0] ones_o,
    output logic [SHOTS_W-1:0] zeros_o,
    output logic               res_valid_o,
    input  logic               res_ready_i
`ifdef QMEAS_STREAM_EN
    ,
    output logic               shot_valid_o,
    output logic               shot_bit_o
`endif
);

    localparam logic [SHOTS_W-1:0] SHOT_ONE = SHOTS_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [PROB_W-1:0]  prob1_lat;
    logic [SHOTS_W-1:0] shots_lat;
    logic [SHOTS_W-1:0] shot_cnt;
    logic               take_shot;
    logic               shot_hit;
    logic               last_shot;
    logic               res_accept;

    assign shot_hit   = outcome_one(rnd_i, prob1_lat);
    assign last_shot  = (shot_cnt == shots_lat - SHOT_ONE);
    assign res_accept = res_valid_o && res_ready_i;
    assign busy_o     = (state != IDLE);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        take_shot = 1'b0;
        case (state)
            IDLE: begin
                if (start_i)
                    state_nxt = (shots_i == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort_i) begin
                    state_nxt = IDLE;
                end else if (rnd_valid_i) begin
                    take_shot = 1'b1;
                    if (last_shot)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (abort_i || res_accept)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // res_valid_o rises one edge after entering DONE, giving the counters their update cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_o <= 1'b0;
            prob1_lat   <= '0;
            shots_lat   <= '0;
            shot_cnt    <= '0;
            ones_o      <= '0;
            zeros_o     <= '0;
        end else begin
            res_valid_o <= (state == DONE) && (state_nxt == DONE);
            if (state == IDLE && start_i) begin
                prob1_lat <= prob1_i;
                shots_lat <= shots_i;
                shot_cnt  <= '0;
                ones_o    <= '0;
                zeros_o   <= '0;
            end else if (state != IDLE && abort_i) begin
                shot_cnt  <= '0;
                ones_o    <= '0;
                zeros_o   <= '0;
            end else if (take_shot) begin
                shot_cnt <= shot_cnt + SHOT_ONE;
                if (shot_hit)
                    ones_o  <= ones_o + SHOT_ONE;
                else
                    zeros_o <= zeros_o + SHOT_ONE;
            end
        end
    end

`ifdef QMEAS_STREAM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shot_valid_o <= 1'b0;
            shot_bit_o   <= 1'b0;
        end else begin
            shot_valid_o <= take_shot;
            shot_bit_o   <= take_shot && shot_hit;
        end
    end
`endif

endmodule

// File: tb/tb_qubit_measure_sampler.sv
// Self-checking bench for qubit_measure_sampler; LFSR-driven shots, scoreboard of expected counts.
module tb_qubit_measure_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rnd_i;
    logic        rnd_valid_i;
    logic        start_i;
    logic [7:0]  prob1_i;
    logic [15:0] shots_i;
    logic        abort_i;
    logic        busy_o;
    logic [15:0] ones_o;
    logic [15:0] zeros_o;
    logic        res_valid_o;
    logic        res_ready_i;
`ifdef QMEAS_STREAM_EN
    logic        shot_valid_o;
    logic        shot_bit_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] lfsr       = 8'hA5;
    bit         force_zero = 1'b0;

    typedef struct {
        logic [15:0] ones;
        logic [15:0] zeros;
    } res_t;
    res_t exp_q[$];

    qubit_measure_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .rnd_i       (rnd_i),
        .rnd_valid_i (rnd_valid_i),
        .start_i     (start_i),
        .prob1_i     (prob1_i),
        .shots_i     (shots_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .ones_o      (ones_o),
        .zeros_o     (zeros_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i)
`ifdef QMEAS_STREAM_EN
        ,
        .shot_valid_o(shot_valid_o),
        .shot_bit_o  (shot_bit_o)
`endif
    );

    always #5 clk = ~clk;

    // Maximal-length 8-bit LFSR, x^8 + x^6 + x^5 + x^4 + 1, period 255 over 1..255.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // One clock: drive inputs, take the edge, sample outputs 1 time unit later.
    task automatic tick(input logic valid);
        rnd_valid_i = valid;
        rnd_i       = force_zero ? 8'h00 : lfsr;
        @(posedge clk);
        #1;
        if (valid)
            lfsr = lfsr_next(lfsr);
    endtask

    task automatic do_run(input logic [7:0] prob, input logic [15:0] shots,
                          input bit toggle, output int lat);
        res_t       exp_r;
        res_t       got;
        logic [7:0] s;
        logic [7:0] r;
`ifdef QMEAS_STREAM_EN
        int pulses = 0;
        int bits   = 0;
`endif
        exp_r.ones  = '0;
        exp_r.zeros = '0;
        s = lfsr;
        for (int i = 0; i < int'(shots); i++) begin
            r = force_zero ? 8'h00 : s;
            if (r <= prob) exp_r.ones  = exp_r.ones + 16'd1;
            else           exp_r.zeros = exp_r.zeros + 16'd1;
            s = lfsr_next(s);
        end
        exp_q.push_back(exp_r);

        prob1_i = prob;
        shots_i = shots;
        start_i = 1'b1;
        tick(1'b0);
        start_i = 1'b0;
        prob1_i = ~prob;
        shots_i = shots + 16'd7;

        lat = 0;
        while (res_valid_o !== 1'b1 && lat < 600) begin
            tick(toggle ? (lat % 2 == 0) : 1'b1);
            lat++;
`ifdef QMEAS_STREAM_EN
            if (shot_valid_o === 1'b1) begin
                pulses++;
                if (shot_bit_o === 1'b1) bits++;
            end
`endif
        end
        rnd_valid_i = 1'b0;
        got = exp_q.pop_front();

        checks++;
        if (res_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL run_timeout prob=%0d shots=%0d: res_valid_o=%b after %0d cycles, required 1",
                     prob, shots, res_valid_o, lat);
        end else begin
            checks++;
            if (ones_o !== got.ones) begin
                failures++;
                $display("FAIL run_ones prob=%0d shots=%0d: got %0d, required %0d", prob, shots, ones_o, got.ones);
            end
            checks++;
            if (zeros_o !== got.zeros) begin
                failures++;
                $display("FAIL run_zeros prob=%0d shots=%0d: got %0d, required %0d", prob, shots, zeros_o, got.zeros);
            end
        end
`ifdef QMEAS_STREAM_EN
        checks++;
        if (pulses != int'(shots) || bits != int'(got.ones)) begin
            failures++;
            $display("FAIL stream prob=%0d shots=%0d: pulses=%0d ones=%0d, required %0d and %0d",
                     prob, shots, pulses, bits, shots, got.ones);
        end
`endif
    endtask

    task automatic accept_result(input string tag);
        res_ready_i = 1'b1;
        tick(1'b0);
        res_ready_i = 1'b0;
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept: res_valid=%b busy=%b, required 0 0", tag, res_valid_o, busy_o);
        end
    endtask

    task automatic expect_lat(input string tag, input int lat, input int req);
        checks++;
        if (lat != req) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, req);
        end
    endtask

    task automatic expect_counts(input string tag, input logic [15:0] o, input logic [15:0] z);
        checks++;
        if (ones_o !== o || zeros_o !== z) begin
            failures++;
            $display("FAIL %s_counts: ones=%0d zeros=%0d, required %0d %0d", tag, ones_o, zeros_o, o, z);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rnd_valid_i = 1'b0; rnd_i = '0; start_i = 1'b0; prob1_i = '0;
        shots_i = '0; abort_i = 1'b0; res_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b0);
        checks++;
        if (busy_o !== 1'b0 || res_valid_o !== 1'b0 || ones_o !== 16'd0 || zeros_o !== 16'd0) begin
            failures++;
            $display("FAIL reset: busy=%b res_valid=%b ones=%0d zeros=%0d, required all 0",
                     busy_o, res_valid_o, ones_o, zeros_o);
        end
    endtask

    task automatic test_prob_zero;
        int lat;
        do_run(8'd0, 16'd100, 1'b0, lat);
        expect_lat("prob0", lat, 101);
        expect_counts("prob0", 16'd0, 16'd100);
        accept_result("prob0");
        // Abort in IDLE must leave the held results alone.
        abort_i = 1'b1;
        tick(1'b0);
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || zeros_o !== 16'd100 || ones_o !== 16'd0) begin
            failures++;
            $display("FAIL idle_abort: busy=%b ones=%0d zeros=%0d, required 0 0 100", busy_o, ones_o, zeros_o);
        end
    endtask

    task automatic test_prob_full;
        int lat;
        do_run(8'd255, 16'd255, 1'b0, lat);
        expect_lat("prob255", lat, 256);
        expect_counts("prob255", 16'd255, 16'd0);
        accept_result("prob255");
    endtask

    task automatic test_half_period;
        int lat;
        do_run(8'd128, 16'd255, 1'b0, lat);
        expect_counts("half", 16'd128, 16'd127);
        accept_result("half");
    endtask

    task automatic test_zero_shots;
        int lat;
        do_run(8'd77, 16'd0, 1'b0, lat);
        expect_lat("zero_shots", lat, 1);
        prob1_i = 8'd255; shots_i = 16'd5; start_i = 1'b1; res_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            checks++;
            if (res_valid_o !== 1'b1 || busy_o !== 1'b1 || ones_o !== 16'd0 || zeros_o !== 16'd0) begin
                failures++;
                $display("FAIL zero_shots_hold cycle %0d: res_valid=%b busy=%b ones=%0d zeros=%0d, required 1 1 0 0",
                         i, res_valid_o, busy_o, ones_o, zeros_o);
            end
        end
        start_i = 1'b0;
        // Abort from DONE drops the pending result.
        abort_i = 1'b1; res_ready_i = 1'b1;
        tick(1'b0);
        abort_i = 1'b0; res_ready_i = 1'b0;
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL done_abort: res_valid=%b busy=%b, required 0 0", res_valid_o, busy_o);
        end
    endtask

    task automatic test_toggle;
        int lat;
        do_run(8'd255, 16'd20, 1'b1, lat);
        expect_lat("toggle", lat, 40);
        expect_counts("toggle", 16'd20, 16'd0);
        accept_result("toggle");
    endtask

    task automatic test_rnd_zero;
        int lat;
        force_zero = 1'b1;
        do_run(8'd0, 16'd3, 1'b0, lat);
        force_zero = 1'b0;
        expect_counts("rnd_zero", 16'd3, 16'd0);
        accept_result("rnd_zero");
    endtask

    task automatic test_abort;
        bit seen = 1'b0;
        prob1_i = 8'd128; shots_i = 16'd100; start_i = 1'b1;
        tick(1'b0);
        start_i = 1'b0;
        repeat (49) tick(1'b1);
        abort_i = 1'b1; start_i = 1'b1; res_ready_i = 1'b1;
        tick(1'b1);
        abort_i = 1'b0; start_i = 1'b0; res_ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || res_valid_o !== 1'b0 || ones_o !== 16'd0 || zeros_o !== 16'd0) begin
            failures++;
            $display("FAIL run_abort: busy=%b res_valid=%b ones=%0d zeros=%0d, required all 0",
                     busy_o, res_valid_o, ones_o, zeros_o);
        end
        for (int i = 0; i < 120; i++) begin
            tick(1'b1);
            if (res_valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
        end
        rnd_valid_i = 1'b0;
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_quiet: res_valid/busy seen 1 after abort, required 0");
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        for (int k = 0; k < 3; k++) begin
            do_run(8'($urandom_range(255)), 16'($urandom_range(40, 1)), bit'(k == 1), lat);
            accept_result("b2b");
        end
    endtask

    task automatic test_reset_mid_run;
        prob1_i = 8'd128; shots_i = 16'd100; start_i = 1'b1;
        tick(1'b0);
        start_i = 1'b0;
        repeat (30) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || res_valid_o !== 1'b0 || ones_o !== 16'd0 || zeros_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b res_valid=%b ones=%0d zeros=%0d, required all 0",
                     busy_o, res_valid_o, ones_o, zeros_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rnd_valid_i = 1'b0;
        tick(1'b0);
        checks++;
        if (busy_o !== 1'b0 || ones_o !== 16'd0) begin
            failures++;
            $display("FAIL post_reset: busy=%b ones=%0d, required 0 0", busy_o, ones_o);
        end
    endtask

    initial begin
        test_reset;
        test_prob_zero;
        test_prob_full;
        test_half_period;
        test_zero_shots;
        test_toggle;
        test_rnd_zero;
        test_abort;
        test_back_to_back;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
